// File: rtl/tap_stream_checker.sv
// Scoreboard comparing an expected-word stream against a DUT actual stream, emitting one TAP result per case.
// Latency: a result appears one cycle after the accept, timeout or drain event that caused it.
// Backpressure: exp_ready drops when the FIFO is full or the run is over; act_ready is high only in RUN; results cannot be stalled.
module tap_stream_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [DATA_WIDTH-1:0] act_data,
    input  logic                  done,
    output logic                  res_valid,
    output logic                  res_pass,
    output logic [2:0]            res_kind,
    output logic [15:0]           res_index,
    output logic [15:0]           pass_count,
    output logic [15:0]           fail_count,
    output logic                  finished,
    output logic                  all_pass
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

    localparam logic [2:0] K_MATCH      = 3'd0;
    localparam logic [2:0] K_MISMATCH   = 3'd1;
    localparam logic [2:0] K_TIMEOUT    = 3'd2;
    localparam logic [2:0] K_UNEXPECTED = 3'd3;
    localparam logic [2:0] K_MISSING    = 3'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        END   = 2'd2
    } state_t;

    state_t                state;
    logic                  armed;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [15:0]           idle_cnt;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  act_acc;
    logic                  pop;
    logic                  ev;
    logic                  ev_pass;
    logic [2:0]            ev_kind;
    logic [15:0]           idle_nxt;
    logic [DATA_WIDTH-1:0] head;

    // armed keeps exp_ready low until the first edge after reset release
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign exp_ready  = armed && (state == RUN) && !fifo_full;
    assign act_ready  = (state == RUN);
    assign push       = exp_valid && exp_ready;
    assign act_acc    = act_valid && act_ready;
    assign head       = mem[rd_ptr];

    // Decide this cycle's pop and result; an accepted actual always beats a timeout
    always_comb begin
        pop      = 1'b0;
        ev       = 1'b0;
        ev_pass  = 1'b0;
        ev_kind  = K_MATCH;
        idle_nxt = 16'd0;
        case (state)
            RUN: begin
                if (act_acc) begin
                    ev = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        ev_pass = (head == act_data);
                        ev_kind = ev_pass ? K_MATCH : K_MISMATCH;
                    end else begin
                        ev_kind = K_UNEXPECTED;
                    end
                end else if (!fifo_empty) begin
                    if (idle_cnt == TO_LAST) begin
                        pop     = 1'b1;
                        ev      = 1'b1;
                        ev_kind = K_TIMEOUT;
                    end else begin
                        idle_nxt = idle_cnt + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ev      = 1'b1;
                    ev_kind = K_MISSING;
                end
            end
            default: ;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    // FIFO pointers, occupancy and idle counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idle_cnt <= 16'd0;
        end else begin
            armed    <= 1'b1;
            idle_cnt <= idle_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Registered result outputs and saturating totals; fields hold between results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            res_kind   <= 3'd0;
            res_index  <= 16'd0;
            pass_count <= 16'd0;
            fail_count <= 16'd0;
        end else begin
            res_valid <= ev;
            if (ev) begin
                res_pass  <= ev_pass;
                res_kind  <= ev_kind;
                res_index <= res_index + 16'd1;
                if (ev_pass) begin
                    if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                end else begin
                    if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                end
            end
        end
    end

    // Run control: RUN -> DRAIN on done, DRAIN -> END once the FIFO is empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            finished <= 1'b0;
            all_pass <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (state)
                RUN: begin
                    if (done) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state    <= END;
                        finished <= 1'b1;
                        all_pass <= (fail_count == 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tap_stream_checker.md
TAP_STREAM_CHECKER -- requirements
Module: tap_stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of compared data words.
REQ-002 SHALL have parameter DEPTH, default 8, expected-FIFO entries, power of two >= 2.
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles allowed per pending expected word (1..65535).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports exp_valid input 1, exp_ready output 1, exp_data input DATA_WIDTH: expected-word stream.
REQ-007 SHALL have ports act_valid input 1, act_ready output 1, act_data input DATA_WIDTH: DUT actual-word stream.
REQ-008 SHALL have port done  input  1  single-cycle request to end the test run.
REQ-009 SHALL have ports res_valid output 1, res_pass output 1, res_kind output 3, res_index output 16: per-test-case result for the TAP logger.
REQ-010 SHALL have ports pass_count output 16, fail_count output 16: running totals.
REQ-011 SHALL have ports finished output 1 (single-cycle pulse), all_pass output 1: end-of-run summary.

Function
REQ-012 SHALL implement states RUN, DRAIN, END; RUN after reset.
REQ-013 Handshake SHALL occur when valid and ready are both high on a rising edge; data SHALL be sampled on that edge.
REQ-014 exp_ready SHALL equal (state==RUN) and FIFO not full; pushes SHALL be visible to comparison from the next cycle.
REQ-015 act_ready SHALL equal (state==RUN); every accepted actual word SHALL produce exactly one result.
REQ-016 Accepted actual with FIFO non-empty SHALL pop the head and compare: equal -> kind 0 (match, pass); unequal -> kind 1 (mismatch, fail).
REQ-017 Accepted actual with FIFO empty (including a push in the same cycle) SHALL give kind 3 (unexpected, fail) and no pop.
REQ-018 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-019 A 16-bit idle counter SHALL increment each RUN cycle with FIFO non-empty and no actual accepted; it SHALL clear on an actual accept or when FIFO is empty.
REQ-020 Idle counter reaching TIMEOUT SHALL pop the head, emit kind 2 (timeout, fail), and clear the counter; an actual accept in the same cycle SHALL take precedence (no timeout).
REQ-021 done in RUN SHALL move to DRAIN next cycle; done in DRAIN or END SHALL be ignored.
REQ-022 DRAIN SHALL pop one remaining entry per cycle emitting kind 4 (missing, fail); with FIFO empty it SHALL move to END.
REQ-023 Entering END SHALL pulse finished for exactly one cycle with all_pass = (fail_count==0) held until reset; END SHALL be terminal.
REQ-024 Results SHALL be registered: res_valid high exactly one cycle after the causing event, no backpressure, at most one result per cycle.
REQ-025 res_index SHALL start at 1 for the first result and increment by 1 per result, wrapping 65535 -> 0.
REQ-026 pass_count and fail_count SHALL update in the same cycle res_valid is high and saturate at 65535.
REQ-027 res_pass, res_kind and res_index SHALL hold their last values while res_valid is low.

Reset
REQ-028 reset_n low SHALL immediately force: state RUN, FIFO empty, idle counter 0, exp_ready 0 (until first edge after release), res_valid 0, res_pass 0, res_kind 0, res_index 0, pass_count 0, fail_count 0, finished 0, all_pass 0.
REQ-029 Reset asserted mid-run SHALL discard pending expected words without emitting results.

Verification
REQ-030 Push 0x11,0x22; send actual 0x11,0x23 -> two results: index 1 kind 0 pass, index 2 kind 1 fail; pass_count 1, fail_count 1.
REQ-031 Push DEPTH=8 words without actuals -> exp_ready low after 8th accept; one actual pops -> exp_ready high next cycle.
REQ-032 TIMEOUT=4, push 0xAA, no actual -> kind 2 fail result 4 idle cycles later; FIFO empty; actual arriving exactly at expiry -> kind 0/1, no timeout.
REQ-033 Actual 0x55 with FIFO empty and simultaneous push of 0x55 -> kind 3 fail; next actual 0x55 -> kind 0 pass.
REQ-034 Push 3 words, match 1, assert done -> two kind 4 results on consecutive cycles, then finished pulse, all_pass 0; further handshakes refused.
REQ-035 Assert reset_n low with 3 words queued -> all outputs at reset values, no res_valid; fresh run behaves as after power-up.
